// File: rtl/prog_sequencer.sv
// Purpose: fetch sequencer owning the program counter, a writable branch-target LUT, the ALU flags and the req/done run handshake.
// Latency: prog_ctr and the flags update one cycle after the executing instruction; the LUT reads combinationally and writes on the clock edge.
// Backpressure: stall freezes the PC, the flags and the state for that cycle, and the branch and flag inputs are ignored while it is high.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   req / done          start request (sampled in IDLE and DONE) / run finished
//   prog_ctr            current instruction address (D bits)
//   instr_valid         instruction at prog_ctr executes this cycle
//   stall               hold PC, flags and state
//   absjump_en          branch to lut[lut_idx]
//   reljump_en          branch to prog_ctr + lut[lut_idx]
//   cond                condition select for both branch types
//   lut_idx             LUT read index
//   lut_wr_en           LUT write strobe
//   lut_wr_idx          LUT write index
//   lut_wr_data         LUT write data
//   zero_i/pari_i/sc_i  ALU flag inputs
//   flag_en/sc_clr/sc_en  flag load controls
//   zeroQ/pariQ/scQ     registered flags
module prog_sequencer #(
  parameter int D         = 12,
  parameter int L         = 5,
  parameter int HALT_ADDR = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  output logic         done,
  output logic [D-1:0] prog_ctr,
  output logic         instr_valid,
  input  logic         stall,
  input  logic         absjump_en,
  input  logic         reljump_en,
  input  logic [1:0]   cond,
  input  logic [L-1:0] lut_idx,
  input  logic         lut_wr_en,
  input  logic [L-1:0] lut_wr_idx,
  input  logic [D-1:0] lut_wr_data,
  input  logic         zero_i,
  input  logic         pari_i,
  input  logic         sc_i,
  input  logic         flag_en,
  input  logic         sc_clr,
  input  logic         sc_en,
  output logic         zeroQ,
  output logic         pariQ,
  output logic         scQ
);

  localparam int           DEPTH   = 1 << L;
  localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         zero_q, zero_d;
  logic         pari_q, pari_d;
  logic         sc_q, sc_d;
  logic [D-1:0] lut_q [DEPTH];
  logic [D-1:0] lut_d [DEPTH];

  logic [D-1:0] lut_rd;
  logic         at_halt;
  logic         exec;
  logic         cond_ok;

  // The branch target comes from the LUT state before this cycle's write.
  // A target written in the same cycle is therefore seen one cycle later.
  assign lut_rd  = lut_q[lut_idx];
  assign at_halt = (pc_q == HALT_PC);
  assign exec    = (state_q == ST_RUN) && !stall && !at_halt;

  assign instr_valid = exec;
  assign done        = (state_q == ST_DONE);
  assign prog_ctr    = pc_q;
  assign zeroQ       = zero_q;
  assign pariQ       = pari_q;
  assign scQ         = sc_q;

  always_comb begin
    cond_ok = 1'b1;
    case (cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = zero_q;
      2'b10:   cond_ok = !zero_q;
      default: cond_ok = sc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zero_d  = zero_q;
    pari_d  = pari_q;
    sc_d    = sc_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        // A stalled cycle holds everything, including the move to DONE.
        if (!stall) begin
          if (at_halt) begin
            state_d = ST_DONE;
          end else begin
            // Absolute wins over relative. Relative wraps modulo 2**D.
            // Because the LUT word is already D bits wide, sign extension is implicit.
            if (absjump_en && cond_ok) begin
              pc_d = lut_rd;
            end else if (reljump_en && cond_ok) begin
              pc_d = pc_q + lut_rd;
            end else begin
              pc_d = pc_q + D'(1);
            end
            if (flag_en) begin
              zero_d = zero_i;
              pari_d = pari_i;
            end
            if (sc_clr) begin
              sc_d = 1'b0;
            end else if (sc_en) begin
              sc_d = sc_i;
            end
          end
        end
      end
      ST_DONE: begin
        if (req) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_comb begin
    lut_d = lut_q;
    if (lut_wr_en) begin
      lut_d[lut_wr_idx] = lut_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      zero_q  <= 1'b0;
      pari_q  <= 1'b0;
      sc_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
      pari_q  <= pari_d;
      sc_q    <= sc_d;
      lut_q   <= lut_d;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer. A D=12 instance is followed by a spec-level model.
// A D=4/HALT=3 instance checks the wrap and LUT write/read cases.
module tb_prog_sequencer;

  localparam int HALT = 128;
  localparam int PCMOD = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance signals
  logic        req, done, instr_valid, stall, absjump_en, reljump_en;
  logic [11:0] prog_ctr, lut_wr_data;
  logic [1:0]  cond;
  logic [4:0]  lut_idx, lut_wr_idx;
  logic        lut_wr_en, zero_i, pari_i, sc_i, flag_en, sc_clr, sc_en;
  logic        zeroQ, pariQ, scQ;

  // small instance signals
  logic       s_req, s_done, s_instr_valid, s_abs;
  logic [3:0] s_pc, s_lut_wr_data;
  logic [1:0] s_lut_idx, s_lut_wr_idx;
  logic       s_lut_wr_en, s_zeroQ, s_pariQ, s_scQ;

  prog_sequencer #(.D(12), .L(5), .HALT_ADDR(128)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .prog_ctr(prog_ctr),
    .instr_valid(instr_valid), .stall(stall), .absjump_en(absjump_en),
    .reljump_en(reljump_en), .cond(cond), .lut_idx(lut_idx),
    .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx), .lut_wr_data(lut_wr_data),
    .zero_i(zero_i), .pari_i(pari_i), .sc_i(sc_i), .flag_en(flag_en),
    .sc_clr(sc_clr), .sc_en(sc_en), .zeroQ(zeroQ), .pariQ(pariQ), .scQ(scQ)
  );

  prog_sequencer #(.D(4), .L(2), .HALT_ADDR(3)) dut_s (
    .clk(clk), .reset(reset), .req(s_req), .done(s_done), .prog_ctr(s_pc),
    .instr_valid(s_instr_valid), .stall(1'b0), .absjump_en(s_abs),
    .reljump_en(1'b0), .cond(2'b00), .lut_idx(s_lut_idx),
    .lut_wr_en(s_lut_wr_en), .lut_wr_idx(s_lut_wr_idx), .lut_wr_data(s_lut_wr_data),
    .zero_i(1'b0), .pari_i(1'b0), .sc_i(1'b0), .flag_en(1'b0),
    .sc_clr(1'b0), .sc_en(1'b0), .zeroQ(s_zeroQ), .pariQ(s_pariQ), .scQ(s_scQ)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  // mode: 0 idle, 1 running, 2 finished
  int m_mode = 0;
  int m_pc = 0;
  bit m_z = 0, m_p = 0, m_sc = 0, m_c = 0;
  int m_lut [32];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_pc = 0; m_z = 0; m_p = 0; m_sc = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      if (m_mode != 1) begin
        if (req) begin m_mode = 1; m_pc = 0; end
      end else if (!stall) begin
        if (m_pc == HALT) begin
          m_mode = 2;
        end else begin
          case (cond)
            2'd0: m_c = 1;
            2'd1: m_c = m_z;
            2'd2: m_c = !m_z;
            default: m_c = m_sc;
          endcase
          if (absjump_en && m_c)      m_pc = m_lut[lut_idx];
          else if (reljump_en && m_c) m_pc = (m_pc + m_lut[lut_idx]) % PCMOD;
          else                        m_pc = (m_pc + 1) % PCMOD;
          if (flag_en) begin m_z = zero_i; m_p = pari_i; end
          if (sc_clr) m_sc = 0;
          else if (sc_en) m_sc = sc_i;
        end
      end
      // The table is updated after the branch read, so the old target is used.
      if (lut_wr_en) m_lut[lut_wr_idx] = int'(lut_wr_data);
    end
  end

  always @(negedge clk) begin
    check("pc", int'(prog_ctr), m_pc);
    check("done", int'(done), int'(m_mode == 2));
    check("instr_valid", int'(instr_valid), int'(m_mode == 1 && !stall && m_pc != HALT));
    check("zeroQ", int'(zeroQ), int'(m_z));
    check("pariQ", int'(pariQ), int'(m_p));
    check("scQ", int'(scQ), int'(m_sc));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_wr(input int idx, input int data);
    lut_wr_en = 1'b1; lut_wr_idx = 5'(idx); lut_wr_data = 12'(data);
    cyc();
    lut_wr_en = 1'b0;
  endtask

  task automatic s_lut_wr(input int idx, input int data);
    s_lut_wr_en = 1'b1; s_lut_wr_idx = 2'(idx); s_lut_wr_data = 4'(data);
    cyc();
    s_lut_wr_en = 1'b0;
  endtask

  task automatic abs_jump(input int idx);
    absjump_en = 1'b1; lut_idx = 5'(idx);
    cyc();
    absjump_en = 1'b0;
  endtask

  int nvalid;

  initial begin
    req = 0; stall = 0; absjump_en = 0; reljump_en = 0; cond = 2'd0; lut_idx = '0;
    lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0; zero_i = 0; pari_i = 0; sc_i = 0;
    flag_en = 0; sc_clr = 0; sc_en = 0;
    s_req = 0; s_abs = 0; s_lut_idx = '0; s_lut_wr_en = 0; s_lut_wr_idx = '0; s_lut_wr_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset_pc", int'(prog_ctr), 0);
    check("reset_done", int'(done), 0);
    check("reset_valid", int'(instr_valid), 0);
    check("reset_flags", int'({zeroQ, pariQ, scQ}), 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    check("idle_valid", int'(instr_valid), 0);

    // Straight-line run to the halt address
    req = 1; cyc(); req = 0;
    check("run1_start_pc", int'(prog_ctr), 0);
    nvalid = 0;
    for (int n = 0; n < 400; n++) begin
      if (done) break;
      if (instr_valid) nvalid++;
      cyc();
    end
    check("run1_done", int'(done), 1);
    check("run1_halt_pc", int'(prog_ctr), 128);
    check("run1_valid_cycles", nvalid, 128);

    // Load branch targets while the sequencer is in DONE
    lut_wr(3, 40); lut_wr(5, 12'hFFC); lut_wr(7, 20); lut_wr(9, 7); lut_wr(10, 50);
    check("done_holds", int'(done), 1);
    req = 1; cyc(); req = 0;
    check("run2_start_pc", int'(prog_ctr), 0);
    check("run2_done_drops", int'(done), 0);
    repeat (10) cyc();
    check("pc_at_10", int'(prog_ctr), 10);

    cond = 2'd0; abs_jump(3);
    check("abs_jump_40", int'(prog_ctr), 40);

    flag_en = 1; zero_i = 1; pari_i = 1; cyc(); flag_en = 0; zero_i = 0; pari_i = 0;
    check("flag_load_pc", int'(prog_ctr), 41);
    check("flag_load_z", int'(zeroQ), 1);
    check("flag_load_p", int'(pariQ), 1);

    abs_jump(7);
    check("abs_jump_20", int'(prog_ctr), 20);
    reljump_en = 1; cond = 2'd1; lut_idx = 5'd5; cyc(); reljump_en = 0; cond = 2'd0;
    check("rel_taken_16", int'(prog_ctr), 16);

    flag_en = 1; zero_i = 0; cyc(); flag_en = 0;
    check("zero_clear", int'(zeroQ), 0);
    abs_jump(7);
    reljump_en = 1; cond = 2'd1; lut_idx = 5'd5; cyc(); reljump_en = 0; cond = 2'd0;
    check("rel_not_taken_21", int'(prog_ctr), 21);

    sc_en = 1; sc_i = 1; sc_clr = 1; cyc(); sc_clr = 0;
    check("sc_clr_priority", int'(scQ), 0);
    cyc(); sc_en = 0; sc_i = 0;
    check("sc_load", int'(scQ), 1);
    check("pc_23", int'(prog_ctr), 23);
    cond = 2'd3; abs_jump(3); cond = 2'd0;
    check("abs_on_sc_40", int'(prog_ctr), 40);
    reljump_en = 1; cond = 2'd2; lut_idx = 5'd5; cyc(); reljump_en = 0; cond = 2'd0;
    check("rel_not_zero_36", int'(prog_ctr), 36);

    // Stall with a pending branch and flag updates that must all be ignored
    abs_jump(9);
    check("pc_at_7", int'(prog_ctr), 7);
    stall = 1; absjump_en = 1; lut_idx = 5'd3; flag_en = 1; zero_i = 1; sc_clr = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall_pc", int'(prog_ctr), 7);
      check("stall_z", int'(zeroQ), 0);
      check("stall_sc", int'(scQ), 1);
      check("stall_valid", int'(instr_valid), 0);
    end
    stall = 0; absjump_en = 0; flag_en = 0; zero_i = 0; sc_clr = 0;
    cyc();
    check("after_stall_8", int'(prog_ctr), 8);

    // Small instance: wraps and same-cycle LUT write/read
    s_lut_wr(1, 15); s_lut_wr(2, 9);
    s_req = 1; cyc(); s_req = 0;
    check("s_start_pc", int'(s_pc), 0);
    s_abs = 1; s_lut_idx = 2'd1; cyc(); s_abs = 0;
    check("s_jump_15", int'(s_pc), 15);
    cyc();
    check("s_wrap_0", int'(s_pc), 0);
    s_lut_wr_en = 1; s_lut_wr_idx = 2'd2; s_lut_wr_data = 4'd5; s_abs = 1; s_lut_idx = 2'd2;
    cyc(); s_lut_wr_en = 0;
    check("s_old_target_9", int'(s_pc), 9);
    cyc(); s_abs = 0;
    check("s_new_target_5", int'(s_pc), 5);
    for (int n = 0; n < 40; n++) begin
      if (s_done) break;
      cyc();
    end
    check("s_done", int'(s_done), 1);
    check("s_halt_pc", int'(s_pc), 3);

    // Asynchronous reset in the middle of a run
    abs_jump(10);
    check("pc_at_50", int'(prog_ctr), 50);
    reset = 1'b0;
    #1;
    check("midreset_pc", int'(prog_ctr), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_valid", int'(instr_valid), 0);
    cyc();
    reset = 1'b1;
    cyc();
    check("post_reset_idle", int'(instr_valid), 0);
    req = 1; cyc(); req = 0;
    check("restart_pc", int'(prog_ctr), 0);
    check("restart_valid", int'(instr_valid), 1);
    abs_jump(3);
    check("lut_lost", int'(prog_ctr), 0);
    cyc();
    check("restart_inc", int'(prog_ctr), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
